aud_rmm_sched: RTL and testbench

// - Shares one aud_rmm (AUD RAM-monitor-mode engine) between N_REQ bus requesters.
// - Round-robin arbitration, then sequences the aud_rmm strobe / idle handshake.
// - Owns the tri-state data bus enable and the completion timeout.
// - Returns read data and an error status to the winning requester.
// - Sits between host-side masters (bridge, trace poller) and aud_rmm, in the aud_ck domain.

---
 rtl/aud_rmm_sched_pkg.sv | 21 ++
 rtl/aud_rr_arb.sv | 45 ++++
 rtl/aud_rmm_sched.sv | 238 +++++++++++++++++++++++
 tb/tb_aud_rmm_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_rmm_sched_pkg.sv
// rtl/aud_rmm_sched_pkg.sv - shared size codes, FSM states and aud_rmm defaults
package aud_rmm_sched_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int STROBE_CYC_DEF  = 3;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/aud_rr_arb.sv
// rtl/aud_rr_arb.sv - round-robin arbiter: combinational grant, registered pointer
module aud_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic             any,
    output logic [IW-1:0]    grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;

    // Scan from the farthest candidate back to the pointer so the nearest set bit wins.
    always_comb begin
        any       = |req;
        grant_idx = ptr_q;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (req[cand[IW-1:0]]) begin
                grant_idx = cand[IW-1:0];
            end
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aud_rmm_sched.sv
// rtl/aud_rmm_sched.sv - shares one aud_rmm engine between N_REQ requesters
module aud_rmm_sched
    import aud_rmm_sched_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 aud_ck,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_write,
    input  logic [32*N_REQ-1:0]  req_addr,
    input  logic [32*N_REQ-1:0]  req_wdata,
    input  logic [2*N_REQ-1:0]   req_size,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [31:0]          rmm_addr,
    output logic [1:0]           rmm_size,
    output logic                 rmm_we,
    output logic                 rmm_re,
    output logic [31:0]          rmm_wdata,
    output logic                 rmm_data_oe,
    input  logic [31:0]          rmm_rdata,
    input  logic                 rmm_err,
    input  logic                 rmm_idle,
    output logic                 timeout_sts
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(STROBE_CYC + 1);

    logic [31:0] addr_a  [N_REQ];
    logic [31:0] wdata_a [N_REQ];
    logic [1:0]  size_a  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_a[i]  = req_addr[32*i +: 32];
        assign wdata_a[i] = req_wdata[32*i +: 32];
        assign size_a[i]  = req_size[2*i +: 2];
    end

    logic          arb_any;
    logic [IW-1:0] arb_idx;
    logic          grant_en;

    aud_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .clk       (aud_ck),
        .rst       (rst),
        .req       (req_valid),
        .advance   (grant_en),
        .any       (arb_any),
        .grant_idx (arb_idx)
    );

    state_e        state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic          write_q, write_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [SW-1:0] strb_q, strb_d;
    logic          busy_seen_q, busy_seen_d;
    logic          to_q, to_d;
    logic [31:0]   cap_rdata_q, cap_rdata_d;
    logic          cap_err_q, cap_err_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rmm_addr_q, rmm_addr_d;
    logic [1:0]    rmm_size_q, rmm_size_d;
    logic          rmm_we_q, rmm_we_d;
    logic          rmm_re_q, rmm_re_d;
    logic [31:0]   rmm_wdata_q, rmm_wdata_d;
    logic          rmm_data_oe_q, rmm_data_oe_d;
    logic          timeout_sts_q, timeout_sts_d;

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        write_d       = write_q;
        cnt_d         = cnt_q;
        strb_d        = strb_q;
        busy_seen_d   = busy_seen_q;
        to_d          = to_q;
        cap_rdata_d   = cap_rdata_q;
        cap_err_d     = cap_err_q;
        rmm_addr_d    = rmm_addr_q;
        rmm_size_d    = rmm_size_q;
        rmm_we_d      = rmm_we_q;
        rmm_re_d      = rmm_re_q;
        rmm_wdata_d   = rmm_wdata_q;
        rmm_data_oe_d = rmm_data_oe_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        timeout_sts_d = timeout_sts_q;
        grant_en      = 1'b0;
        // Counter includes the ISSUE entry cycle and saturates at the limit.
        cnt_inc       = (cnt_q == CW'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (arb_any && rmm_idle) begin
                    grant_en             = 1'b1;
                    g_d                  = arb_idx;
                    req_ready_d[arb_idx] = 1'b1;
                    write_d              = req_write[arb_idx];
                    cap_rdata_d          = '0;
                    cap_err_d            = 1'b0;
                    if (size_a[arb_idx] == SZ_ILL) begin
                        state_d   = ST_RESP;
                        cap_err_d = 1'b1;
                    end else begin
                        state_d       = ST_ISSUE;
                        rmm_addr_d    = addr_a[arb_idx];
                        rmm_size_d    = size_a[arb_idx];
                        rmm_we_d      = req_write[arb_idx];
                        rmm_re_d      = ~req_write[arb_idx];
                        rmm_data_oe_d = req_write[arb_idx];
                        rmm_wdata_d   = req_write[arb_idx] ? wdata_a[arb_idx] : '0;
                        strb_d        = SW'(1);
                        cnt_d         = CW'(1);
                        busy_seen_d   = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                busy_seen_d = busy_seen_q | ~rmm_idle;
                cnt_d       = cnt_inc;
                if (strb_q == SW'(STROBE_CYC)) begin
                    rmm_we_d = 1'b0;
                    rmm_re_d = 1'b0;
                    state_d  = ST_WAIT;
                end else begin
                    strb_d = strb_q + 1'b1;
                end
                if (cnt_inc == CW'(TIMEOUT_CYC)) begin
                    rmm_we_d    = 1'b0;
                    rmm_re_d    = 1'b0;
                    state_d     = ST_RESP;
                    cap_rdata_d = '0;
                    cap_err_d   = 1'b1;
                    to_d        = 1'b1;
                end
            end
            ST_WAIT: begin
                busy_seen_d = busy_seen_q | ~rmm_idle;
                cnt_d       = cnt_inc;
                if (busy_seen_q && rmm_idle) begin
                    state_d     = ST_RESP;
                    cap_rdata_d = write_q ? '0 : rmm_rdata;
                    cap_err_d   = rmm_err;
                end else if (cnt_inc == CW'(TIMEOUT_CYC)) begin
                    state_d     = ST_RESP;
                    cap_rdata_d = '0;
                    cap_err_d   = 1'b1;
                    to_d        = 1'b1;
                end
            end
            default: begin
                rsp_valid_d[g_q] = 1'b1;
                rsp_rdata_d      = cap_rdata_q;
                rsp_err_d        = cap_err_q;
                timeout_sts_d    = timeout_sts_q | to_q;
                to_d             = 1'b0;
                busy_seen_d      = 1'b0;
                rmm_addr_d       = '0;
                rmm_size_d       = '0;
                rmm_wdata_d      = '0;
                rmm_data_oe_d    = 1'b0;
                state_d          = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aud_ck or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            g_q           <= '0;
            write_q       <= 1'b0;
            cnt_q         <= '0;
            strb_q        <= '0;
            busy_seen_q   <= 1'b0;
            to_q          <= 1'b0;
            cap_rdata_q   <= '0;
            cap_err_q     <= 1'b0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rmm_addr_q    <= '0;
            rmm_size_q    <= '0;
            rmm_we_q      <= 1'b0;
            rmm_re_q      <= 1'b0;
            rmm_wdata_q   <= '0;
            rmm_data_oe_q <= 1'b0;
            timeout_sts_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            write_q       <= write_d;
            cnt_q         <= cnt_d;
            strb_q        <= strb_d;
            busy_seen_q   <= busy_seen_d;
            to_q          <= to_d;
            cap_rdata_q   <= cap_rdata_d;
            cap_err_q     <= cap_err_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rmm_addr_q    <= rmm_addr_d;
            rmm_size_q    <= rmm_size_d;
            rmm_we_q      <= rmm_we_d;
            rmm_re_q      <= rmm_re_d;
            rmm_wdata_q   <= rmm_wdata_d;
            rmm_data_oe_q <= rmm_data_oe_d;
            timeout_sts_q <= timeout_sts_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rmm_addr    = rmm_addr_q;
    assign rmm_size    = rmm_size_q;
    assign rmm_we      = rmm_we_q;
    assign rmm_re      = rmm_re_q;
    assign rmm_wdata   = rmm_wdata_q;
    assign rmm_data_oe = rmm_data_oe_q;
    assign timeout_sts = timeout_sts_q;

endmodule

// File: tb/tb_aud_rmm_sched.sv
// tb/tb_aud_rmm_sched.sv - self-checking bench for aud_rmm_sched
module tb_aud_rmm_sched;

    localparam int N       = 2;
    localparam int STROBE  = 3;
    localparam int TIMEOUT = 1024;

    logic              aud_ck = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [32*N-1:0]   req_addr, req_wdata;
    logic [2*N-1:0]    req_size;
    logic [31:0]       rsp_rdata, rmm_addr, rmm_wdata, rmm_rdata;
    logic              rsp_err, rmm_we, rmm_re, rmm_data_oe, rmm_err, rmm_idle, timeout_sts;
    logic [1:0]        rmm_size;

    aud_rmm_sched #(.N_REQ(N), .STROBE_CYC(STROBE), .TIMEOUT_CYC(TIMEOUT)) dut (
        .aud_ck(aud_ck), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rmm_addr(rmm_addr), .rmm_size(rmm_size), .rmm_we(rmm_we), .rmm_re(rmm_re),
        .rmm_wdata(rmm_wdata), .rmm_data_oe(rmm_data_oe), .rmm_rdata(rmm_rdata),
        .rmm_err(rmm_err), .rmm_idle(rmm_idle), .timeout_sts(timeout_sts)
    );

    always #5 aud_ck = ~aud_ck;

    int checks = 0;
    int errors = 0;

    // Behavioural aud_rmm: busy for m_busy cycles after a strobe, data = addr ^ m_mask.
    int          m_busy = 8;
    logic        m_err  = 1'b0;
    logic        m_hang = 1'b0;
    logic [31:0] m_mask = '0;

    logic        f_write [N];
    logic [31:0] f_addr  [N];
    logic [31:0] f_wdata [N];
    logic [1:0]  f_size  [N];
    int          m_ptr  = 0;
    logic        sticky = 1'b0;
    int          grants[$];

    initial begin
        int   left;
        logic active;
        rmm_idle  = 1'b1;
        rmm_rdata = '0;
        rmm_err   = 1'b0;
        active    = 1'b0;
        left      = 0;
        forever begin
            @(negedge aud_ck);
            if (rst) begin
                active   = 1'b0;
                rmm_idle = 1'b1;
            end else if (!active) begin
                if (rmm_we || rmm_re) begin
                    active    = 1'b1;
                    left      = m_busy;
                    rmm_idle  = 1'b0;
                    rmm_rdata = rmm_addr ^ m_mask;
                    rmm_err   = m_err;
                end
            end else begin
                if (left > 0) left--;
                if (left == 0 && !m_hang) begin
                    rmm_idle = 1'b1;
                    active   = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_rdata, rsp_err, rmm_addr, rmm_size,
                 rmm_we, rmm_re, rmm_wdata, rmm_data_oe, timeout_sts};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic set_fields(input int i, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] s);
        f_write[i] = w; f_addr[i] = a; f_wdata[i] = d; f_size[i] = s;
        req_write[i]          = w;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        req_size[2*i +: 2]    = s;
    endtask

    task automatic new_fields(input int i);
        set_fields(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
    endtask

    // Serves every requester in mask (plus rereq re-requests) and checks each completion.
    task automatic run_batch(input logic [N-1:0] mask, input int rereq);
        logic [N-1:0] pend;
        int cur, rdy_at, t, we_n, re_n, oe_n, bad_n, left, eg;
        logic ill, wr;
        pend = mask; cur = -1; rdy_at = 0; left = rereq; t = 0;
        we_n = 0; re_n = 0; oe_n = 0; bad_n = 0;
        req_valid = mask;
        while ((pend != '0 || cur >= 0) && t < 5000) begin
            @(negedge aud_ck);
            t++;
            if (req_ready != '0) begin
                eg = rr_pick(pend);
                chk("req_ready_grant", req_ready, onehot(eg));
                chk("grant_while_busy", cur, -1);
                if (eg >= 0) begin
                    cur = eg; m_ptr = (eg + 1) % N;
                    pend[eg] = 1'b0; req_valid[eg] = 1'b0;
                    grants.push_back(eg);
                end
                rdy_at = t; we_n = 0; re_n = 0; oe_n = 0; bad_n = 0;
            end
            if (rmm_we) we_n++;
            if (rmm_re) re_n++;
            if (rmm_data_oe) oe_n++;
            if (cur >= 0 && (rmm_we || rmm_re)) begin
                if (rmm_addr !== f_addr[cur] || rmm_size !== f_size[cur] ||
                    (rmm_we && rmm_wdata !== f_wdata[cur])) bad_n++;
            end
            if (rsp_valid != '0) begin
                chk("rsp_without_grant", cur >= 0, 1'b1);
                if (cur >= 0) begin
                    ill = (f_size[cur] == 2'd3);
                    wr  = f_write[cur] && !ill;
                    if (m_hang && !ill) sticky = 1'b1;
                    chk("rsp_valid", rsp_valid, onehot(cur));
                    chk("rsp_rdata", rsp_rdata,
                        (ill || f_write[cur] || m_hang) ? 32'h0 : (f_addr[cur] ^ m_mask));
                    chk("rsp_err", rsp_err, ill || m_hang || m_err);
                    chk("we_cycles", we_n, wr ? STROBE : 0);
                    chk("re_cycles", re_n, (!ill && !f_write[cur]) ? STROBE : 0);
                    chk("oe_cycles", oe_n, wr ? (t - rdy_at) : 0);
                    chk("rmm_fields", bad_n, 0);
                    chk("timeout_sts", timeout_sts, sticky);
                    if (ill) chk("ill_latency", (t - rdy_at) >= 1 && (t - rdy_at) <= 2, 1'b1);
                    if (m_hang && !ill) chk("timeout_latency", t - rdy_at, TIMEOUT);
                    if (left > 0) begin
                        left--;
                        new_fields(cur);
                        pend[cur] = 1'b1;
                        req_valid[cur] = 1'b1;
                    end
                end
                cur = -1;
            end
        end
        chk("batch_complete", (pend == '0) && (cur < 0), 1'b1);
    endtask

    initial begin
        int t, seen;
        int exp_order[4];
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
        repeat (3) @(negedge aud_ck);
        chk("reset_outputs", any_out(), 1'b0);
        rst = 1'b0;
        @(negedge aud_ck);

        m_busy = 16; m_mask = '0; m_err = 1'b0;
        set_fields(0, 1'b1, 32'h0123_4567, 32'h89AB_CDEF, 2'd2);
        run_batch(2'b01, 0);

        set_fields(1, 1'b0, 32'h0123_4567, 32'h0, 2'd2);
        run_batch(2'b10, 0);

        set_fields(0, 1'b1, 32'h0000_1000, 32'h5555_AAAA, 2'd3);
        run_batch(2'b01, 0);

        m_hang = 1'b1;
        set_fields(1, 1'b0, 32'h0000_2000, 32'h0, 2'd1);
        run_batch(2'b10, 0);
        m_hang = 1'b0;
        repeat (3) @(negedge aud_ck);

        m_hang = 1'b1;
        set_fields(0, 1'b1, 32'hCAFE_0000, 32'h0000_1234, 2'd2);
        req_valid = 2'b01;
        t = 0;
        while (req_ready == '0 && t < 50) begin
            @(negedge aud_ck);
            t++;
        end
        chk("rst_test_grant", req_ready, 2'b01);
        req_valid = '0;
        repeat (5) @(negedge aud_ck);
        #2 rst = 1'b1;
        #1 chk("mid_wait_reset_outputs", any_out(), 1'b0);
        repeat (2) @(negedge aud_ck);
        rst = 1'b0; m_hang = 1'b0; m_ptr = 0; sticky = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge aud_ck);
            if (rsp_valid != '0) seen++;
        end
        chk("no_rsp_after_reset", seen, 0);
        m_busy = 6; m_mask = 32'hFFFF_0000;
        set_fields(0, 1'b0, 32'h1357_9BDF, 32'h0, 2'd0);
        run_batch(2'b01, 0);

        rst = 1'b1;
        set_fields(0, 1'b1, 32'h0000_00A0, 32'hA0A0_A0A0, 2'd2);
        set_fields(1, 1'b0, 32'h0000_00B0, 32'h0, 2'd2);
        req_valid = 2'b11;
        repeat (2) @(negedge aud_ck);
        rst = 1'b0; m_ptr = 0; sticky = 1'b0;
        grants.delete();
        run_batch(2'b11, 2);
        exp_order = '{0, 1, 0, 1};
        chk("contention_count", grants.size(), 4);
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            chk("contention_order", grants[k], exp_order[k]);
        end

        for (int b = 0; b < 15; b++) begin
            logic [N-1:0] mask;
            mask   = N'($urandom_range(1, (1 << N) - 1));
            m_busy = $urandom_range(4, 20);
            m_err  = ($urandom_range(0, 3) == 0);
            m_mask = $urandom;
            for (int i = 0; i < N; i++) if (mask[i]) new_fields(i);
            run_batch(mask, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
